// File: rtl/ac2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ac2_pkg
// Brief    : Shared types, width helpers and saturation limits for the AC2
//            accumulate stage.
// Revision : 1.0
// ============================================================================
package ac2_pkg;

    typedef logic [1:0] ac2_ch_t;

    localparam int CNT_MAX = 255;

    function automatic int ac2_w(input int m, input int pa);
        return $clog2(m) + pa + 1;
    endfunction

    function automatic int ac2_aw(input int m, input int pa, input int g);
        return ac2_w(m, pa) + g;
    endfunction

    // Limits returned as 64-bit values; callers truncate to their width.
    function automatic longint ac2_sat_pos(input int aw);
        return (64'sd1 <<< (aw - 1)) - 64'sd1;
    endfunction

    function automatic longint ac2_sat_neg(input int aw);
        return -(64'sd1 <<< (aw - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ac2_sat_add.sv
`default_nettype none
// ============================================================================
// Module   : ac2_sat_add
// Brief    : AW-bit signed adder with overflow flag; saturates when the
//            AC2_SAT_EN macro is defined, otherwise wraps.
// Revision : 1.0
// ============================================================================
module ac2_sat_add
    import ac2_pkg::*;
#(
    parameter int AW = 17
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [AW-1:0] raw;

    assign raw = a + b;
    // Overflow only when both operands share a sign the result does not.
    assign ovf = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);

`ifdef AC2_SAT_EN
    localparam logic [AW-1:0] SAT_POS = AW'(ac2_sat_pos(AW));
    localparam logic [AW-1:0] SAT_NEG = AW'(ac2_sat_neg(AW));

    assign sum = ovf ? (a[AW-1] ? SAT_NEG : SAT_POS) : raw;
`else
    assign sum = raw;
`endif

endmodule
`default_nettype wire

// File: rtl/ac2_acc_stage.sv
`default_nettype none
// ============================================================================
// Module   : ac2_acc_stage
// Brief    : Four-channel accumulate stage with a one-entry valid/ready result
//            register. Optional macro AC2_SAT_EN selects saturating adds.
// Revision : 1.0
// ============================================================================
module ac2_acc_stage
    import ac2_pkg::*;
#(
    parameter int M  = 16,
    parameter int Pa = 8,
    parameter int G  = 4,
    localparam int W  = ac2_w(M, Pa),
    localparam int AW = ac2_aw(M, Pa, G)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic [1:0]    in_ch,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [AW-1:0] out_data,
    output logic [1:0]    out_ch,
    output logic [7:0]    out_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    ovf
);

    logic [AW-1:0] acc [4];
    logic [7:0]    cnt [4];
    logic [3:0]    ovf_r;
    logic [3:0]    ovf_next;

    ac2_ch_t       sel_ch;
    logic          accept;
    logic          drain;
    logic [AW-1:0] add_a;
    logic [AW-1:0] add_b;
    logic [AW-1:0] add_sum;
    logic          add_ovf;
    logic [7:0]    cnt_inc;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign sel_ch   = in_ch;

    assign add_a   = acc[sel_ch];
    assign add_b   = {{G{in_data[W-1]}}, in_data};
    assign cnt_inc = (cnt[sel_ch] == 8'(CNT_MAX)) ? cnt[sel_ch] : cnt[sel_ch] + 8'd1;

    ac2_sat_add #(
        .AW (AW)
    ) u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // A handed-off result clears its channel flag; a fresh overflow on the
    // same channel in that cycle belongs to the new segment and wins.
    always_comb begin
        ovf_next = ovf_r;
        if (drain) begin
            ovf_next[out_ch] = 1'b0;
        end
        if (accept && add_ovf) begin
            ovf_next[sel_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
            ovf_r     <= '0;
            out_data  <= '0;
            out_ch    <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            ovf_r <= ovf_next;
            if (drain) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    out_data    <= add_sum;
                    out_ch      <= sel_ch;
                    out_cnt     <= cnt_inc;
                    out_valid   <= 1'b1;
                    acc[sel_ch] <= '0;
                    cnt[sel_ch] <= '0;
                end else begin
                    acc[sel_ch] <= add_sum;
                    cnt[sel_ch] <= cnt_inc;
                end
            end
        end
    end

    assign ovf = ovf_r;

endmodule
`default_nettype wire

// File: tb/tb_ac2_acc_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac2_acc_stage
// Brief    : Self-checking bench for ac2_acc_stage (honours AC2_SAT_EN).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ac2_acc_stage;

    localparam int     W    = 13;
    localparam int     AW   = 17;
    localparam longint MAXV = 65535;
    localparam longint MINV = -65536;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic [1:0]    in_ch = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [AW-1:0] out_data;
    logic [1:0]    out_ch;
    logic [7:0]    out_cnt;
    logic          out_valid;
    logic [3:0]    ovf;

    always #5 clk = ~clk;

    ac2_acc_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_ch     (in_ch),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: true integer sums per channel, then wrap or clamp.
    longint     m_acc [4] = '{0, 0, 0, 0};
    int         m_cnt [4] = '{0, 0, 0, 0};
    logic [3:0] m_ovf = '0;
    bit         m_valid = 0;
    longint     m_data = 0;
    int         m_ch = 0;
    int         m_cnt_out = 0;
    bit         chk_en = 0;
    bit         m_ok;
    longint     m_s;
    int         m_c;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_acc[i] = 0;
                m_cnt[i] = 0;
            end
            m_ovf = '0; m_valid = 0; m_data = 0; m_ch = 0; m_cnt_out = 0;
        end else begin
            m_ok = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) begin
                m_valid = 0;
                m_ovf[m_ch] = 1'b0;
            end
            if (m_ok) begin
                m_s = m_acc[in_ch] + longint'($signed(in_data));
                if (m_s > MAXV || m_s < MINV) begin
                    m_ovf[in_ch] = 1'b1;
`ifdef AC2_SAT_EN
                    m_s = (m_s > MAXV) ? MAXV : MINV;
`else
                    m_s = ((m_s - MINV + 262144) % 131072) + MINV;
`endif
                end
                m_c = (m_cnt[in_ch] >= 255) ? 255 : m_cnt[in_ch] + 1;
                if (in_last) begin
                    m_data = m_s; m_ch = int'(in_ch); m_cnt_out = m_c; m_valid = 1;
                    m_acc[in_ch] = 0; m_cnt[in_ch] = 0;
                end else begin
                    m_acc[in_ch] = m_s; m_cnt[in_ch] = m_c;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", longint'(in_ready), longint'(!m_valid || out_ready));
            check("out_valid", longint'(out_valid), longint'(m_valid));
            check("ovf", longint'(ovf), longint'(m_ovf));
            if (m_valid) begin
                check("out_data", longint'($signed(out_data)), m_data);
                check("out_ch", longint'(out_ch), longint'(m_ch));
                check("out_cnt", longint'(out_cnt), longint'(m_cnt_out));
            end
        end
    end

    task automatic step(input bit v, input int ch, input int d, input bit last, input bit ordy);
        @(negedge clk); #1;
        in_valid  = v;
        in_ch     = 2'(ch);
        in_data   = W'(d);
        in_last   = last;
        out_ready = ordy;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pin(input string n, input longint d, input int ch, input int c);
        @(negedge clk);
        check({n, "_valid"}, longint'(out_valid), 1);
        check({n, "_data"}, longint'($signed(out_data)), d);
        check({n, "_ch"}, longint'(out_ch), longint'(ch));
        check({n, "_cnt"}, longint'(out_cnt), longint'(c));
    endtask

    initial begin
        longint exp_ovf_data;
        bit     v, l, r;
        repeat (3) @(posedge clk);
        chk_en = 1;
        @(negedge clk);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_data", longint'(out_data), 0);
        check("rst_cnt", longint'(out_cnt), 0);
        #1 rst = 1'b0;

        // Basic segment and single-cycle result presence.
        step(1, 0, 10, 0, 1);
        step(1, 0, 20, 0, 1);
        step(1, 0, 30, 1, 1);
        pin("seg0", 60, 0, 3);
        @(negedge clk);
        check("seg0_one_cycle", longint'(out_valid), 0);

        // Interleaved channels.
        step(1, 1, 5, 0, 1);
        step(1, 2, -7, 0, 1);
        step(1, 1, 3, 1, 1);
        pin("il1", 8, 1, 2);
        step(1, 2, -1, 1, 1);
        pin("il2", -8, 2, 2);

        // Back-pressure, then drain together with a new last beat.
        step(1, 0, 7, 1, 0);
        pin("hold", 7, 0, 1);
        step(1, 3, -2, 0, 0);
        @(negedge clk);
        check("stall_in_ready", longint'(in_ready), 0);
        check("stall_data", longint'($signed(out_data)), 7);
        step(1, 3, 4, 1, 1);
        pin("nobubble", 4, 3, 1);

        // Large sum without overflow.
        for (int i = 0; i < 10; i++) step(1, 0, 4095, 0, 1);
        step(1, 0, 4095, 1, 1);
        pin("big", 45045, 0, 11);
        check("big_ovf0", longint'(ovf[0]), 0);

        // Overflow.
        for (int i = 0; i < 17; i++) step(1, 0, 4095, 0, 1);
        step(1, 0, 4095, 1, 1);
`ifdef AC2_SAT_EN
        exp_ovf_data = 65535;
`else
        exp_ovf_data = -57362;
`endif
        pin("ovfl", exp_ovf_data, 0, 18);
        check("ovfl_flag", longint'(ovf[0]), 1);
        @(negedge clk);
        check("ovfl_clear", longint'(ovf[0]), 0);

        // Beat counter saturation.
        for (int i = 0; i < 300; i++) step(1, 1, 1, 0, 1);
        step(1, 1, 1, 1, 1);
        pin("cntsat", 301, 1, 255);

        // Reset in the middle of a segment.
        step(1, 2, 100, 0, 1);
        step(1, 2, 200, 0, 1);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        step(1, 2, 1, 1, 1);
        pin("midrst", 1, 2, 1);
        check("midrst_ovf", longint'(ovf), 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) != 0);
            l = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            r = ($urandom_range(0, 3) != 0);
            step(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 8191)) - 4096, l, r);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ac2_acc_stage.md
# ac2_acc_stage

Four-channel accumulate stage that sits directly downstream of the AC2 channel mux. Each cycle it accepts at most one partial sum tagged with a 2-bit channel index and adds it into that channel's private accumulator. On a beat marked last, it emits the channel's final sum through a one-entry valid/ready output register and clears that accumulator. This stage closes a dot-product segment for one of the four shift-register lanes.

## Interface
Parameters:
- M, 16, register depth; sets input width.
- Pa, 8, activation precision; sets input width.
- G, 4, guard bits added to accumulator width.
- Derived W = $clog2(M)+Pa+1 (input width, default 13); AW = W+G (accumulator/output width, default 17).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  W  signed two's-complement partial sum from the mux.
- in_ch  in  2  channel index (the mux select), 0..3.
- in_valid  in  1  beat present.
- in_last  in  1  final beat of the segment for in_ch.
- in_ready  out  1  stage can accept a beat.
- out_data  out  AW  signed final sum.
- out_ch  out  2  channel of out_data.
- out_cnt  out  8  number of beats in the segment, saturating at 255.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  consumer takes the result.
- ovf  out  4  sticky per-channel overflow flag; cleared on that channel's result emission or on reset.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. It is combinational and stalls all beats, including non-last beats, while the output is full and not draining.
- On an accepted non-last beat: acc[in_ch] <= acc[in_ch] + sext(in_data), and cnt[in_ch] increments, saturating at 255.
- On an accepted last beat:
  - out_data <= acc[in_ch] + sext(in_data);
  - out_ch <= in_ch;
  - out_cnt <= cnt[in_ch]+1, saturating;
  - out_valid <= 1;
  - acc[in_ch] and cnt[in_ch] clear to 0.
- A last beat arriving on a fresh channel (cnt = 0) produces out_data = sext(in_data) and out_cnt = 1.
- Channels are fully independent. Interleaved beats across channels are legal in any order.
- Overflow: ovf[ch] sets when the AW-bit signed add changes sign incorrectly. Without saturation the sum wraps modulo 2^AW.
- out_valid clears when out_ready is high and no new last beat is accepted in the same cycle.
- Simultaneous drain and new last beat: the new result loads in the same cycle, out_valid stays 1, and there is no bubble.
- Reset, including mid-segment: all acc, cnt, ovf, out_data, out_ch and out_cnt go to 0, and out_valid goes to 0. Any partial segment is discarded.

## Timing
- Latency: a last beat accepted at edge t is visible on the out_* ports after edge t, i.e. 1 cycle.
- Accumulator update is also visible 1 cycle after acceptance. Back-to-back beats to the same channel are supported at full rate with no hazard.
- Throughput: 1 beat/cycle while the consumer keeps out_ready high.
- out_data, out_ch and out_cnt hold stable while out_valid && !out_ready.
- in_ready has no registered delay; its only combinational path is from out_ready.

## Configuration
- AC2_SAT_EN defined: the adder saturates to +2^(AW-1)-1 or -2^(AW-1) on overflow. ovf still sets.
- AC2_SAT_EN undefined: the adder wraps. ovf still sets.
- The macro applies identically to accumulate beats and last beats.

## Structure
- Package ac2_pkg holds:
  - width helpers for W and AW as functions of M, Pa and G;
  - typedef ac2_ch_t (logic [1:0]);
  - constant CNT_MAX = 255;
  - the saturation limit constants.
- One sub-module, ac2_sat_add: an AW-bit signed adder producing sum and overflow, with saturation gated by AC2_SAT_EN. It is instantiated once and shared by the selected channel.
- The four accumulators are an array indexed by in_ch.

## Test plan
- Reset, then ch0 beats 10, 20 and last 30 with out_ready=1 -> out_data=60, out_ch=0, out_cnt=3, out_valid high for exactly 1 cycle.
- Interleave: ch1 beat 5, ch2 beat -7, ch1 last 3, ch2 last -1 -> results in order: (ch1, 8, cnt 2), then (ch2, -8, cnt 2).
- Hold out_ready=0 with a result pending and present a ch3 beat -> in_ready=0, ch3 accumulator unchanged, output stable. Then raise out_ready together with a ch3 last of 4 -> no bubble, next out_data=4, out_cnt=1.
- Ten last-free beats of 4095 on ch0, then last 4095 (sum 45045 < 65535) -> out_data=45045, ovf[0]=0.
- Overflow: 17 beats of 4095 on ch0 plus last 4095 (total 73710) -> with AC2_SAT_EN, out_data=65535 and ovf[0]=1; without it, out_data wraps to 73710-131072 = -57362 and ovf[0]=1. ovf[0] clears after the emission.
- Assert rst mid-segment after ch2 beats 100, 200, then ch2 last 1 -> out_data=1, out_cnt=1, all ovf=0.
